// File: rtl/fetch_exec_sequencer_if.sv
// Control bundle between the fetch/execute sequencer and the datapath it steers.
// The sequencer side is the master: it consumes status inputs and drives enables/selects.
interface fetch_exec_sequencer_if;
    logic        run;
    logic [31:0] IR;
    logic        MFC;
    logic        cond_true;

    logic        IRE;
    logic        MDRE;
    logic        MARE;
    logic        PCE;
    logic        nPCE;
    logic        PSRE;
    logic        RFE;
    logic        MFA;
    logic [1:0]  MAR_SEL;
    logic [1:0]  MDR_SEL;
    logic [1:0]  nPC_SEL;
    logic [1:0]  ALU_SEL;
    logic [1:0]  CIN_SEL;
    logic [1:0]  RC_SEL;
    logic        RA_SEL;
    logic        MOP_SEL;
    logic        AOP_SEL;
    logic [5:0]  OP1;
    logic [3:0]  state;
    logic        mem_err;

    modport master (
        input  run, IR, MFC, cond_true,
        output IRE, MDRE, MARE, PCE, nPCE, PSRE, RFE, MFA,
               MAR_SEL, MDR_SEL, nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL,
               RA_SEL, MOP_SEL, AOP_SEL, OP1, state, mem_err
    );

    modport slave (
        output run, IR, MFC, cond_true,
        input  IRE, MDRE, MARE, PCE, nPCE, PSRE, RFE, MFA,
               MAR_SEL, MDR_SEL, nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL,
               RA_SEL, MOP_SEL, AOP_SEL, OP1, state, mem_err
    );
endinterface

// File: rtl/fetch_exec_sequencer.sv
// Moore control sequencer: fetch, decode and execute ALU, load/store and branch
// instructions, with a memory-wait timeout that parks the machine in ERROR.
module fetch_exec_sequencer (
    input  logic                          Clk,
    input  logic                          Clr,
    fetch_exec_sequencer_if.master        bus
);
    typedef enum logic [3:0] {
        RESET_ST   = 4'd0,
        FETCH_ADDR = 4'd1,
        FETCH_MEM  = 4'd2,
        FETCH_IR   = 4'd3,
        DECODE     = 4'd4,
        EXEC_ALU   = 4'd5,
        MEM_ADDR   = 4'd6,
        STORE_DATA = 4'd7,
        MEM_ACCESS = 4'd8,
        LOAD_WB    = 4'd9,
        BRANCH     = 4'd10,
        UPDATE_PC  = 4'd11,
        ERROR      = 4'd15
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [3:0] wcnt_inc;
    logic       in_wait;
    logic       timeout;
    logic       is_store;
    logic       unused_ir;

    assign is_store  = bus.IR[21];
    assign unused_ir = ^{bus.IR[29:25], bus.IR[20:14], bus.IR[12:0]};
    assign in_wait   = (state_q == FETCH_MEM) || (state_q == MEM_ACCESS);
    assign wcnt_inc  = wcnt_q + 4'd1;
    // A completing MFC takes priority over the count reaching its limit.
    assign timeout   = !bus.MFC && (wcnt_inc == 4'd15);

    // Outside the wait states the counter sits at zero, which clears it on entry.
    always_comb begin
        wcnt_d = 4'd0;
        if (in_wait) begin
            wcnt_d = bus.MFC ? wcnt_q : wcnt_inc;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET_ST:   state_d = FETCH_ADDR;
            FETCH_ADDR: if (bus.run) state_d = FETCH_MEM;
            FETCH_MEM: begin
                if (bus.MFC)      state_d = FETCH_IR;
                else if (timeout) state_d = ERROR;
            end
            FETCH_IR:   state_d = DECODE;
            DECODE: begin
                case (bus.IR[31:30])
                    2'b10:   state_d = EXEC_ALU;
                    2'b11:   state_d = MEM_ADDR;
                    2'b00:   state_d = (bus.IR[24:22] == 3'b010) ? BRANCH : UPDATE_PC;
                    default: state_d = UPDATE_PC;
                endcase
            end
            EXEC_ALU:   state_d = UPDATE_PC;
            MEM_ADDR:   state_d = is_store ? STORE_DATA : MEM_ACCESS;
            STORE_DATA: state_d = MEM_ACCESS;
            MEM_ACCESS: begin
                if (bus.MFC)      state_d = is_store ? UPDATE_PC : LOAD_WB;
                else if (timeout) state_d = ERROR;
            end
            LOAD_WB:    state_d = UPDATE_PC;
            BRANCH:     state_d = FETCH_ADDR;
            UPDATE_PC:  state_d = FETCH_ADDR;
            ERROR:      state_d = ERROR;
            default:    state_d = RESET_ST;
        endcase
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= RESET_ST;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign bus.state = state_q;

    // Output decode from the registered state; reset forces RESET_ST and thus idle outputs.
    always_comb begin
        bus.IRE     = 1'b1;
        bus.MDRE    = 1'b1;
        bus.MARE    = 1'b1;
        bus.PCE     = 1'b1;
        bus.nPCE    = 1'b1;
        bus.PSRE    = 1'b1;
        bus.RFE     = 1'b1;
        bus.MFA     = 1'b0;
        bus.MAR_SEL = 2'd0;
        bus.MDR_SEL = 2'd0;
        bus.nPC_SEL = 2'd0;
        bus.ALU_SEL = 2'd0;
        bus.CIN_SEL = 2'd0;
        bus.RC_SEL  = 2'd0;
        bus.RA_SEL  = 1'b0;
        bus.MOP_SEL = 1'b0;
        bus.AOP_SEL = 1'b0;
        bus.OP1     = 6'h00;
        bus.mem_err = 1'b0;
        case (state_q)
            FETCH_ADDR: begin
                if (bus.run) begin
                    bus.MAR_SEL = 2'd1;
                    bus.MARE    = 1'b0;
                end
            end
            FETCH_MEM: begin
                bus.MOP_SEL = 1'b1;
                bus.OP1     = 6'h08;
                bus.MFA     = 1'b1;
                bus.MDR_SEL = 2'd0;
                bus.MDRE    = ~bus.MFC;
            end
            FETCH_IR: bus.IRE = 1'b0;
            EXEC_ALU: begin
                bus.RA_SEL  = 1'b0;
                bus.ALU_SEL = {1'b0, bus.IR[13]};
                bus.AOP_SEL = 1'b0;
                bus.CIN_SEL = 2'd2;
                bus.RC_SEL  = 2'd0;
                bus.RFE     = 1'b0;
                bus.PSRE    = ~bus.IR[23];
            end
            MEM_ADDR: begin
                bus.RA_SEL  = 1'b0;
                bus.ALU_SEL = {1'b0, bus.IR[13]};
                bus.AOP_SEL = 1'b1;
                bus.OP1     = 6'h00;
                bus.MAR_SEL = 2'd0;
                bus.MARE    = 1'b0;
            end
            STORE_DATA: begin
                bus.RA_SEL  = 1'b1;
                bus.MDR_SEL = 2'd1;
                bus.MDRE    = 1'b0;
            end
            MEM_ACCESS: begin
                bus.MOP_SEL = 1'b0;
                bus.MFA     = 1'b1;
                if (!is_store) begin
                    bus.MDR_SEL = 2'd0;
                    bus.MDRE    = ~bus.MFC;
                end
            end
            LOAD_WB: begin
                bus.CIN_SEL = 2'd3;
                bus.RC_SEL  = 2'd0;
                bus.RFE     = 1'b0;
            end
            BRANCH: begin
                bus.PCE     = 1'b0;
                bus.nPCE    = 1'b0;
                bus.nPC_SEL = bus.cond_true ? 2'd2 : 2'd0;
            end
            UPDATE_PC: begin
                bus.nPC_SEL = 2'd0;
                bus.PCE     = 1'b0;
                bus.nPCE    = 1'b0;
            end
            ERROR: bus.mem_err = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Self-checking bench: each instruction is expanded into the expected per-cycle state
// trace from the instruction class and memory latencies, then replayed against the DUT.
module tb_fetch_exec_sequencer;
    logic Clk = 1'b0;
    logic Clr;

    fetch_exec_sequencer_if bus();

    fetch_exec_sequencer dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] st;
        logic       mfc;
        logic       run;
    } ent_t;

    ent_t plan[$];

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Required outputs for a state, packed in a fixed order.
    function automatic logic [29:0] exp_out(input logic [3:0] st, input logic [31:0] ir,
                                            input logic mfc, input logic run, input logic cond);
        logic ire, mdre, mare, pce, npce, psre, rfe, mfa, ra, mop, aop, merr;
        logic [1:0] mar, mdr, npc, alu, cin, rc;
        logic [5:0] op1;
        {ire, mdre, mare, pce, npce, psre, rfe} = 7'h7F;
        {mfa, ra, mop, aop, merr} = 5'h0;
        {mar, mdr, npc, alu, cin, rc} = 12'h0;
        op1 = 6'h00;
        case (st)
            4'd1:  if (run) begin mar = 2'd1; mare = 1'b0; end
            4'd2:  begin mop = 1'b1; op1 = 6'h08; mfa = 1'b1; mdre = ~mfc; end
            4'd3:  ire = 1'b0;
            4'd5:  begin alu = {1'b0, ir[13]}; cin = 2'd2; rfe = 1'b0; psre = ~ir[23]; end
            4'd6:  begin alu = {1'b0, ir[13]}; aop = 1'b1; mare = 1'b0; end
            4'd7:  begin ra = 1'b1; mdr = 2'd1; mdre = 1'b0; end
            4'd8:  begin mfa = 1'b1; if (!ir[21]) mdre = ~mfc; end
            4'd9:  begin cin = 2'd3; rfe = 1'b0; end
            4'd10: begin pce = 1'b0; npce = 1'b0; npc = cond ? 2'd2 : 2'd0; end
            4'd11: begin pce = 1'b0; npce = 1'b0; end
            4'd15: merr = 1'b1;
            default: ;
        endcase
        return {ire, mdre, mare, pce, npce, psre, rfe, mfa, mar, mdr, npc, alu, cin, rc,
                ra, mop, aop, op1, merr};
    endfunction

    function automatic logic [29:0] obs_out();
        return {bus.IRE, bus.MDRE, bus.MARE, bus.PCE, bus.nPCE, bus.PSRE, bus.RFE, bus.MFA,
                bus.MAR_SEL, bus.MDR_SEL, bus.nPC_SEL, bus.ALU_SEL, bus.CIN_SEL, bus.RC_SEL,
                bus.RA_SEL, bus.MOP_SEL, bus.AOP_SEL, bus.OP1, bus.mem_err};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic mfc, input logic run);
        ent_t e;
        e.st  = st;
        e.mfc = mfc;
        e.run = run;
        plan.push_back(e);
    endtask

    // Memory wait: 'lat' cycles without MFC, then completion; 15 or more idle cycles time out.
    task automatic push_wait(input logic [3:0] st, input int lat, output bit err);
        err = 1'b0;
        if (lat >= 15) begin
            for (int i = 0; i < 15; i++) push(st, 1'b0, rb());
            for (int i = 0; i < 3; i++) push(4'd15, rb(), rb());
            err = 1'b1;
        end else begin
            for (int i = 0; i < lat; i++) push(st, 1'b0, rb());
            push(st, 1'b1, rb());
        end
    endtask

    task automatic build_instr(input logic [31:0] ir, input int fl, input int ml,
                               input int halts, output bit err);
        for (int i = 0; i < halts; i++) push(4'd1, rb(), 1'b0);
        push(4'd1, rb(), 1'b1);
        push_wait(4'd2, fl, err);
        if (err) return;
        push(4'd3, rb(), rb());
        push(4'd4, rb(), rb());
        if (ir[31:30] == 2'b10) begin
            push(4'd5, rb(), rb());
            push(4'd11, rb(), rb());
        end else if (ir[31:30] == 2'b11) begin
            push(4'd6, rb(), rb());
            if (ir[21]) push(4'd7, rb(), rb());
            push_wait(4'd8, ml, err);
            if (err) return;
            if (!ir[21]) push(4'd9, rb(), rb());
            push(4'd11, rb(), rb());
        end else if (ir[31:30] == 2'b00 && ir[24:22] == 3'b010) begin
            push(4'd10, rb(), rb());
        end else begin
            push(4'd11, rb(), rb());
        end
    endtask

    task automatic run_plan(input logic [31:0] ir, input logic cond);
        foreach (plan[i]) begin
            @(negedge Clk);
            bus.IR        = ir;
            bus.run       = plan[i].run;
            bus.MFC       = plan[i].mfc;
            bus.cond_true = cond;
            #1;
            check($sformatf("state_step%0d", i), 32'(bus.state), 32'(plan[i].st));
            check($sformatf("outputs_st%0d", plan[i].st), 32'(obs_out()),
                  32'(exp_out(plan[i].st, ir, plan[i].mfc, plan[i].run, cond)));
        end
        plan.delete();
    endtask

    // Called just after a sampling point; Clr acts before the next rising edge.
    task automatic reset_pulse();
        #2;
        Clr = 1'b1;
        #1;
        check("clr_state", 32'(bus.state), 32'd0);
        check("clr_outputs", 32'(obs_out()), 32'(exp_out(4'd0, bus.IR, bus.MFC, bus.run, bus.cond_true)));
        @(negedge Clk);
        Clr = 1'b0;
        #1;
        check("clr_release_state", 32'(bus.state), 32'd0);
    endtask

    task automatic do_instr(input logic [31:0] ir, input int fl, input int ml,
                            input int halts, input logic cond);
        bit err;
        build_instr(ir, fl, ml, halts, err);
        run_plan(ir, cond);
        if (err) reset_pulse();
    endtask

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 11);
        if (r < 9) return $urandom_range(0, 4);
        else if (r == 9) return 13;
        else if (r == 10) return 14;
        return 15;
    endfunction

    initial begin
        logic [31:0] ir;
        Clr = 1'b1;
        bus.run = 1'b1;
        bus.IR = 32'h0;
        bus.MFC = 1'b0;
        bus.cond_true = 1'b0;
        #1;
        check("reset_state", 32'(bus.state), 32'd0);
        check("reset_outputs", 32'(obs_out()), 32'(exp_out(4'd0, 32'h0, 1'b0, 1'b1, 1'b0)));
        @(negedge Clk);
        Clr = 1'b0;
        #1;
        check("reset_release_state", 32'(bus.state), 32'd0);

        do_instr(32'hA2044012, 2, 0, 0, 1'b0);   // ALU, MFC after two idle cycles
        do_instr(32'hC2006004, 0, 0, 0, 1'b1);   // load, immediate MFC
        do_instr(32'hC2206004, 1, 3, 0, 1'b1);   // store
        do_instr(32'h10800004, 0, 0, 0, 1'b1);   // branch taken
        do_instr(32'h10800004, 1, 0, 0, 1'b0);   // branch not taken
        do_instr(32'h00000000, 0, 0, 4, 1'b0);   // halted with run=0, then no-op
        do_instr(32'hA2844012, 14, 0, 0, 1'b0);  // MFC at the last allowed fetch cycle
        do_instr(32'hC2006004, 0, 14, 0, 1'b0);  // same boundary on a load
        do_instr(32'hA2044012, 15, 0, 0, 1'b0);  // fetch timeout into ERROR
        do_instr(32'hC2206004, 0, 15, 0, 1'b0);  // store timeout into ERROR

        // Clear in the middle of a fetch with MFA active.
        push(4'd1, 1'b0, 1'b1);
        push(4'd2, 1'b0, 1'b1);
        push(4'd2, 1'b0, 1'b1);
        run_plan(32'hA2044012, 1'b0);
        reset_pulse();

        for (int n = 0; n < 60; n++) begin
            ir = $urandom;
            ir[31:30] = 2'($urandom_range(0, 3));
            if (ir[31:30] == 2'b00 && rb()) ir[24:22] = 3'b010;
            do_instr(ir, pick_lat(), pick_lat(), $urandom_range(0, 2), rb());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_exec_sequencer.md
FETCH_EXEC_SEQUENCER -- requirements
Module: fetch_exec_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- Clk  in  1  rising-edge clock.
- Clr  in  1  async active-high reset.
- run  in  1  1 = start/continue fetching; 0 = halt at FETCH_ADDR.
- IR  in  32  instruction register contents.
- MFC  in  1  memory function complete.
- cond_true  in  1  branch condition result from the external condition tester.
- IRE, MDRE, MARE, PCE, nPCE, PSRE, RFE  out  1 each  load enables, active-low (0 = load on the next Clk edge).
- MFA  out  1  memory function active.
- MAR_SEL, MDR_SEL, nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL  out  2 each  datapath mux selects.
- RA_SEL, MOP_SEL, AOP_SEL  out  1 each  datapath mux selects.
- OP1  out  6  sequencer-forced ALU/memory opcode.
- state  out  4  current state code.
- mem_err  out  1  memory timeout flag.

Function
REQ-003 SHALL be a Moore FSM; all outputs are decoded from the registered state and IR. In wait states only, MDRE also depends on MFC.
REQ-004 Default output values in every state SHALL be:
- all active-low enables = 1; MFA = 0.
- all selects = 0; OP1 = 6'h00; mem_err = 0.
REQ-005 State codes SHALL be:
- RESET_ST=0, FETCH_ADDR=1, FETCH_MEM=2, FETCH_IR=3, DECODE=4, EXEC_ALU=5.
- MEM_ADDR=6, STORE_DATA=7, MEM_ACCESS=8, LOAD_WB=9, BRANCH=10, UPDATE_PC=11, ERROR=15.
REQ-006 RESET_ST SHALL go to FETCH_ADDR unconditionally.
REQ-007 FETCH_ADDR SHALL drive MAR_SEL=1 and MARE=0 only when run=1, then go to FETCH_MEM. When run=0 it SHALL hold with no enables asserted.
REQ-008 FETCH_MEM SHALL drive MOP_SEL=1, OP1=6'h08, MFA=1 and MDR_SEL=0. It SHALL drive MDRE=0 while MFC=1 and go to FETCH_IR when MFC is sampled 1.
REQ-009 FETCH_IR SHALL drive IRE=0, then go to DECODE.
REQ-010 DECODE SHALL produce no enables and SHALL branch on IR:
- IR[31:30]=10 -> EXEC_ALU.
- IR[31:30]=11 -> MEM_ADDR.
- IR[31:30]=00 with IR[24:22]=010 -> BRANCH.
- anything else -> UPDATE_PC (treated as a no-op).
REQ-011 EXEC_ALU SHALL drive RA_SEL=0, ALU_SEL={1'b0,IR[13]}, AOP_SEL=0, CIN_SEL=2, RC_SEL=0 and RFE=0. It SHALL drive PSRE=0 only if IR[23]=1. Next state is UPDATE_PC.
REQ-012 MEM_ADDR SHALL drive RA_SEL=0, ALU_SEL={1'b0,IR[13]}, AOP_SEL=1, OP1=6'h00, MAR_SEL=0 and MARE=0. Next state is STORE_DATA if IR[21]=1 (store), else MEM_ACCESS.
REQ-013 STORE_DATA SHALL drive RA_SEL=1, MDR_SEL=1 and MDRE=0, then go to MEM_ACCESS.
REQ-014 MEM_ACCESS SHALL drive MOP_SEL=0 and MFA=1.
- For loads it SHALL also drive MDR_SEL=0, with MDRE=0 while MFC=1.
- On MFC sampled 1: loads go to LOAD_WB, stores go to UPDATE_PC.
REQ-015 LOAD_WB SHALL drive CIN_SEL=3, RC_SEL=0 and RFE=0, then go to UPDATE_PC.
REQ-016 BRANCH SHALL drive PCE=0 and nPCE=0, with nPC_SEL=2 if cond_true=1, else nPC_SEL=0. Next state is FETCH_ADDR.
REQ-017 UPDATE_PC SHALL drive nPC_SEL=0, PCE=0 and nPCE=0, then go to FETCH_ADDR.
REQ-018 A 4-bit wait counter SHALL be cleared on entry to FETCH_MEM or MEM_ACCESS and SHALL increment on each cycle there with MFC=0.
- If it reaches 15 with MFC=0, the next state SHALL be ERROR.
- MFC=1 on the same edge as the count reaching 15 SHALL win (normal progress).
REQ-019 ERROR SHALL drive mem_err=1 with all enables idle and SHALL be left only by Clr.
REQ-020 run SHALL be sampled only in FETCH_ADDR; an instruction in progress always completes.

Reset
REQ-021 Clr=1 SHALL force state=RESET_ST, clear the wait counter and set all outputs to the REQ-004 defaults immediately, in any state including mid-memory-access (MFA drops asynchronously).
REQ-022 After Clr falls, the first rising Clk edge SHALL move RESET_ST to FETCH_ADDR.

Verification
REQ-023 Reset: Clr pulse while in FETCH_MEM with MFA=1 -> MFA=0 and state=0 immediately; state=1 one Clk after release.
REQ-024 ALU op: IR=32'hA2044012, MFC returned after 2 cycles -> states 1,2,2,2,3,4,5,11,1; in state 5, RFE=0, CIN_SEL=2, ALU_SEL=0, PSRE=1.
REQ-025 Load: IR=32'hC2006004, MFC on the first MEM_ACCESS cycle -> states 4,6,8,9,11; in state 6, ALU_SEL=1 and MARE=0; in state 9, CIN_SEL=3 and RFE=0.
REQ-026 Store: IR=32'hC2206004 -> states 4,6,7,8,11; STORE_DATA drives RA_SEL=1 and MDRE=0; MDRE stays 1 in MEM_ACCESS.
REQ-027 Branch: IR=32'h10800004 -> with cond_true=1, state 10 gives nPC_SEL=2; with cond_true=0, nPC_SEL=0; PCE=nPCE=0 in both cases.
REQ-028 Timeout and halt:
- MFC held 0 in FETCH_MEM -> state=15 and mem_err=1 after 15 wait cycles; MFC=1 at count 15 -> FETCH_IR instead.
- run=0 -> state stays 1 with MARE=1.
